// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch unit: default geometry and
// the fetch state encoding.
package cpu_pkg;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned ADDR_WIDTH = 10;
    localparam int unsigned LONG_BIT   = DATA_WIDTH - 1;

    // FETCH: address on the bus, read accepted when memory is not busy.
    // WAIT : read data returning from memory this cycle.
    // HOLD : instruction presented to the decoder until accepted.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    // Number of words occupied by an instruction, from its long flag.
    function automatic logic [1:0] instr_len(input logic is_long);
        return is_long ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/cpu_fetch.sv
// Instruction fetch unit: reads one (or two) words from instruction memory,
// presents the instruction to the decoder with a valid/ready handshake and
// advances the program counter by the instruction length on acceptance.
// A jump request overrides everything and restarts fetching at its target.
module cpu_fetch #(
    parameter int unsigned DATA_WIDTH = cpu_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
    parameter int unsigned LONG_BIT   = DATA_WIDTH - 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_busy,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data_0,
    input  logic [DATA_WIDTH-1:0] mem_data_1,
    input  logic                  jump_valid,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_word_0,
    output logic [DATA_WIDTH-1:0] instr_word_1,
    output logic                  instr_long,
    output logic [ADDR_WIDTH-1:0] instr_pc
);

    import cpu_pkg::*;

    fetch_state_t          state;
    fetch_state_t          state_next;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic                  load_instr;
    logic                  accept;
    logic                  word0_long;

    assign mem_addr   = pc;
    assign word0_long = mem_data_0[LONG_BIT];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, next-pc and datapath control; a jump overrides every state.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        load_instr = 1'b0;
        accept     = 1'b0;
        if (jump_valid) begin
            state_next = FETCH;
            pc_next    = jump_addr;
        end else begin
            unique case (state)
                FETCH: begin
                    if (!mem_busy) begin
                        state_next = WAIT;
                    end
                end
                WAIT: begin
                    load_instr = 1'b1;
                    state_next = HOLD;
                end
                HOLD: begin
                    if (instr_valid && instr_ready) begin
                        accept     = 1'b1;
                        state_next = FETCH;
                        pc_next    = pc + ADDR_WIDTH'(instr_len(instr_long));
                    end
                end
                default: begin
                    state_next = FETCH;
                end
            endcase
        end
    end

    // Program counter; wraps modulo 2^ADDR_WIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else begin
            pc <= pc_next;
        end
    end

    // Instruction output registers: captured from memory in WAIT, held until
    // accepted; a jump only drops valid, the stale words are never presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_valid  <= 1'b0;
            instr_word_0 <= '0;
            instr_word_1 <= '0;
            instr_long   <= 1'b0;
            instr_pc     <= '0;
        end else if (jump_valid) begin
            instr_valid <= 1'b0;
        end else if (load_instr) begin
            instr_valid  <= 1'b1;
            instr_word_0 <= mem_data_0;
            instr_word_1 <= word0_long ? mem_data_1 : '0;
            instr_long   <= word0_long;
            instr_pc     <= pc;
        end else if (accept) begin
            instr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_fetch.sv
// Self-checking bench for cpu_fetch: directed sequences, a table of decode and
// wrap cases, and a randomized run against a behavioural fetch model.
module tb_cpu_fetch;

    logic        clk;
    logic        rst_n;
    logic        mem_busy;
    logic [9:0]  mem_addr;
    logic [15:0] mem_data_0;
    logic [15:0] mem_data_1;
    logic        jump_valid;
    logic [9:0]  jump_addr;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_word_0;
    logic [15:0] instr_word_1;
    logic        instr_long;
    logic [9:0]  instr_pc;

    logic [15:0] mem [0:1023];
    logic [9:0]  addr_p1;
    int          cyc;
    int          n_total;
    int          n_pass;

    cpu_fetch #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (10),
        .LONG_BIT   (15)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_busy     (mem_busy),
        .mem_addr     (mem_addr),
        .mem_data_0   (mem_data_0),
        .mem_data_1   (mem_data_1),
        .jump_valid   (jump_valid),
        .jump_addr    (jump_addr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_word_0 (instr_word_0),
        .instr_word_1 (instr_word_1),
        .instr_long   (instr_long),
        .instr_pc     (instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read instruction memory: a read happens on every non-busy edge.
    assign addr_p1 = mem_addr + 10'd1;
    always @(posedge clk) begin
        if (!mem_busy) begin
            mem_data_0 <= mem[mem_addr];
            mem_data_1 <= mem[addr_p1];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    task automatic wait_valid(input int limit, output int at);
        at = -1;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (instr_valid === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_total++;
            $display("FAIL valid_timeout: instr_valid got 0 expected 1 within %0d cycles", limit);
        end
    endtask

    typedef struct {
        logic [9:0]  addr;
        logic [15:0] wa;
        logic [15:0] wb;
        logic [15:0] exp_w1;
        logic        exp_long;
        logic [9:0]  exp_next;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int          t;
        int          t_prev;
        int          c0;
        logic [42:0] snap;
        logic [9:0]  a2;
        logic [9:0]  mpc;
        logic [9:0]  mpc1;
        logic        mv;
        logic        iss;
        logic        r_busy;
        logic        r_ready;
        logic        r_jv;
        logic [9:0]  r_ja;
        logic [15:0] ew1;
        int          accepted;

        n_total = 0;
        n_pass  = 0;
        rst_n = 1'b0; mem_busy = 1'b0; instr_ready = 1'b0;
        jump_valid = 1'b0; jump_addr = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[0] = 16'h0001; mem[1] = 16'h8002; mem[2] = 16'h1234; mem[3] = 16'h0005;
        mem[4] = 16'h0042; mem[10'h100] = 16'h0777;

        vecs[0] = '{10'h010, 16'h1234, 16'hFFFF, 16'h0000, 1'b0, 10'h011};
        vecs[1] = '{10'h020, 16'h8001, 16'h5555, 16'h5555, 1'b1, 10'h022};
        vecs[2] = '{10'h3FF, 16'h8000, 16'hABCD, 16'hABCD, 1'b1, 10'h001};
        vecs[3] = '{10'h3FF, 16'h7FFF, 16'h1111, 16'h0000, 1'b0, 10'h000};
        vecs[4] = '{10'h3FE, 16'hFFFF, 16'h2222, 16'h2222, 1'b1, 10'h000};

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_valid", instr_valid, 0);
        chk("rst_w0", instr_word_0, 0);
        chk("rst_w1", instr_word_1, 0);
        chk("rst_long", instr_long, 0);
        chk("rst_pc", instr_pc, 0);
        chk("rst_addr", mem_addr, 0);

        // Straight-line program with the decoder always ready.
        instr_ready = 1'b1;
        rst_n = 1'b1;
        c0 = cyc;
        wait_valid(20, t);
        chk("seq0_latency", t - c0, 2);
        chk("seq0_pc", instr_pc, 0);
        chk("seq0_w0", instr_word_0, 16'h0001);
        chk("seq0_w1", instr_word_1, 0);
        chk("seq0_long", instr_long, 0);
        t_prev = t;
        wait_valid(20, t);
        chk("seq1_gap", t - t_prev, 3);
        chk("seq1_pc", instr_pc, 1);
        chk("seq1_w0", instr_word_0, 16'h8002);
        chk("seq1_w1", instr_word_1, 16'h1234);
        chk("seq1_long", instr_long, 1);
        t_prev = t;
        wait_valid(20, t);
        instr_ready = 1'b0;
        chk("seq2_gap", t - t_prev, 3);
        chk("seq2_pc", instr_pc, 3);
        chk("seq2_w0", instr_word_0, 16'h0005);
        chk("seq2_long", instr_long, 0);

        // Decoder stalls for 5 cycles: the presented instruction must not move.
        snap = {10'd3, 16'h0005, 16'h0000, 1'b0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", instr_valid, 1);
            chk("hold_outputs", {instr_pc, instr_word_0, instr_word_1, instr_long}, snap);
        end
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        chk("hold_release_valid", instr_valid, 0);
        chk("hold_release_pc", mem_addr, 4);

        // Memory busy for 3 cycles while fetching pc 4.
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("busy_addr", mem_addr, 4);
            chk("busy_valid", instr_valid, 0);
        end
        mem_busy = 1'b0;
        c0 = cyc;
        wait_valid(20, t);
        chk("busy_latency", t - c0, 2);
        chk("busy_pc", instr_pc, 4);
        chk("busy_w0", instr_word_0, 16'h0042);

        // Jump coinciding with acceptance: jump wins, no pc step.
        jump_valid = 1'b1; jump_addr = 10'h100; instr_ready = 1'b1;
        @(negedge clk);
        jump_valid = 1'b0; instr_ready = 1'b0;
        chk("jump_drop_valid", instr_valid, 0);
        chk("jump_addr", mem_addr, 10'h100);
        wait_valid(20, t);
        chk("jump_pc", instr_pc, 10'h100);
        chk("jump_w0", instr_word_0, 16'h0777);

        // Decode and wrap-around table.
        for (int v = 0; v < 5; v++) begin
            a2 = vecs[v].addr + 10'd1;
            mem[vecs[v].addr] = vecs[v].wa;
            mem[a2] = vecs[v].wb;
            jump_valid = 1'b1; jump_addr = vecs[v].addr;
            @(negedge clk);
            jump_valid = 1'b0;
            wait_valid(20, t);
            chk("tbl_pc", instr_pc, vecs[v].addr);
            chk("tbl_w0", instr_word_0, vecs[v].wa);
            chk("tbl_w1", instr_word_1, vecs[v].exp_w1);
            chk("tbl_long", instr_long, vecs[v].exp_long);
            instr_ready = 1'b1;
            @(negedge clk);
            instr_ready = 1'b0;
            chk("tbl_next_pc", mem_addr, vecs[v].exp_next);
            chk("tbl_next_valid", instr_valid, 0);
        end

        // Asynchronous reset while an instruction is presented.
        wait_valid(20, t);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_hold_valid", instr_valid, 0);
        chk("areset_hold_w0", instr_word_0, 0);
        chk("areset_hold_long", instr_long, 0);
        chk("areset_hold_pc", instr_pc, 0);
        chk("areset_hold_addr", mem_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        c0 = cyc;
        #1 chk("areset_restart_addr", mem_addr, 0);
        wait_valid(20, t);
        chk("areset_restart_lat", t - c0, 2);
        chk("areset_restart_pc", instr_pc, 0);
        chk("areset_restart_w0", instr_word_0, mem[0]);

        // Asynchronous reset during the memory-wait cycle.
        jump_valid = 1'b1; jump_addr = 10'h050;
        @(negedge clk);
        jump_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_wait_valid", instr_valid, 0);
        chk("areset_wait_addr", mem_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("areset_wait_after_addr", mem_addr, 0);
        chk("areset_wait_after_valid", instr_valid, 0);

        // Randomized run against a behavioural model of the fetch protocol.
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mpc = '0; mv = 1'b0; iss = 1'b0; accepted = 0;
        for (int n = 0; n < 1500; n++) begin
            chk("rnd_addr", mem_addr, mpc);
            chk("rnd_valid", instr_valid, mv);
            if (mv) begin
                mpc1 = mpc + 10'd1;
                ew1 = mem[mpc][15] ? mem[mpc1] : 16'h0000;
                chk("rnd_instr", {instr_pc, instr_word_0, instr_word_1, instr_long},
                    {mpc, mem[mpc], ew1, mem[mpc][15]});
            end
            r_busy  = ($urandom % 4) == 0;
            r_ready = ($urandom % 2) == 0;
            r_jv    = ($urandom % 16) == 0;
            r_ja    = 10'($urandom);
            mem_busy = r_busy; instr_ready = r_ready;
            jump_valid = r_jv; jump_addr = r_ja;
            if (r_jv) begin
                mpc = r_ja; mv = 1'b0; iss = 1'b0;
            end else if (mv) begin
                if (r_ready) begin
                    mpc = mpc + (mem[mpc][15] ? 10'd2 : 10'd1);
                    mv = 1'b0; iss = 1'b0;
                    accepted++;
                end
            end else if (iss) begin
                mv = 1'b1;
            end else if (!r_busy) begin
                iss = 1'b1;
            end
            @(negedge clk);
        end
        mem_busy = 1'b0; instr_ready = 1'b0; jump_valid = 1'b0;
        chk("rnd_progress", accepted > 50, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cpu_fetch.md
CPU_FETCH -- requirements
Module: cpu_fetch

Interface
REQ-001 Parameter DATA_WIDTH, default 16, instruction word width.
REQ-002 Parameter ADDR_WIDTH, default 10, instruction memory word-address width.
REQ-003 Parameter LONG_BIT, default DATA_WIDTH-1, bit of word 0 that marks a two-word instruction.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 mem_busy  input  1  instruction memory is being written this cycle, so no read is performed.
REQ-007 mem_addr  output  ADDR_WIDTH  read address to instruction memory.
REQ-008 mem_data_0  input  DATA_WIDTH  word at the last accepted read address, valid one cycle after the read.
REQ-009 mem_data_1  input  DATA_WIDTH  word at the last accepted read address + 1, with the same timing.
REQ-010 jump_valid  input  1  redirect request.
REQ-011 jump_addr  input  ADDR_WIDTH  redirect target.
REQ-012 instr_valid  output  1  instruction presented to decoder.
REQ-013 instr_ready  input  1  decoder accepts instruction.
REQ-014 instr_word_0  output  DATA_WIDTH  first instruction word.
REQ-015 instr_word_1  output  DATA_WIDTH  second word; zero for one-word instructions.
REQ-016 instr_long  output  1  1 = two-word instruction.
REQ-017 instr_pc  output  ADDR_WIDTH  address of instr_word_0.

Function
REQ-018 The state machine SHALL have the states FETCH, WAIT and HOLD.
REQ-019 mem_addr SHALL equal pc combinationally in every state.
REQ-020 FETCH: at the clock edge, if mem_busy=0, go to WAIT; otherwise stay in FETCH and re-issue the same address.
REQ-021 WAIT: latch instr_word_0 = mem_data_0, instr_long = mem_data_0[LONG_BIT], instr_word_1 = (long ? mem_data_1 : 0), instr_pc = pc; set instr_valid=1; go to HOLD.
REQ-022 HOLD: instr_valid=1; outputs SHALL be held stable until instr_valid && instr_ready.
REQ-023 On acceptance: pc <= pc + (instr_long ? 2 : 1), instr_valid <= 0, go to FETCH.
REQ-024 pc arithmetic SHALL be modulo 2^ADDR_WIDTH; pc = max with a long instruction wraps to 1.
REQ-025 Latency from read issue to instr_valid SHALL be 2 cycles when mem_busy=0; peak throughput is 1 instruction per 3 cycles.
REQ-026 jump_valid=1 in any state: pc <= jump_addr, instr_valid <= 0, go to FETCH; any latched or in-flight instruction is discarded.
REQ-027 jump_valid and acceptance in the same cycle: the jump wins, and pc SHALL NOT be incremented.
REQ-028 mem_busy asserted in WAIT or HOLD SHALL have no effect, because the data was already captured by the memory.

Reset
REQ-029 rst_n=0 SHALL set, immediately: state=FETCH, pc=0, instr_valid=0, instr_word_0=0, instr_word_1=0, instr_long=0, instr_pc=0.
REQ-030 Reset mid-operation SHALL drop any presented instruction without a handshake; fetch restarts from address 0 after release.

Structure
REQ-031 The shared package cpu_pkg SHALL hold DATA_WIDTH, ADDR_WIDTH, LONG_BIT and the fetch state encoding.
REQ-032 The block SHALL be a single module with no sub-module; the state register, pc register and instruction output registers are all local.

Verification
REQ-033 Memory [0]=0x0001, [1]=0x8002, [2]=0x1234, [3]=0x0005; instr_ready=1 -> (pc 0, 0x0001, long 0), (pc 1, 0x8002/0x1234, long 1), (pc 3, 0x0005), each 3 cycles apart.
REQ-034 instr_ready=0 for 5 cycles in HOLD -> outputs stable for all 5 cycles; after ready=1, pc advances exactly once.
REQ-035 mem_busy=1 for 3 cycles in FETCH at pc 4 -> mem_addr stays 4; instr_valid rises 2 cycles after busy falls.
REQ-036 jump_valid with jump_addr=0x100 during HOLD together with instr_ready=1 -> the held instruction is dropped, the next instr_pc is 0x100, and no pc+len step occurs.
REQ-037 pc=0x3FF holding long word 0x8000 and [0]=0xABCD -> instr_word_1=0xABCD, next pc=0x001.
REQ-038 rst_n=0 asserted asynchronously during WAIT -> instr_valid=0 within the same cycle; after release, mem_addr=0.
